cv32e40x_obi_trans_responder: RTL and testbench

Bus-side responder for the core's MPU/PMA transaction interface. It accepts PMA-approved transactions with a valid/ready handshake and holds each one as a stable OBI address phase until the bus grants it. It tracks outstanding transactions in a small in-order FIFO and returns OBI responses to the MPU, tagged with the original access type. It also drives the "one transaction pending next cycle" indication that the MPU uses to time its error responses.

---
 rtl/cv32e40x_obi_trans_responder_if.sv | 46 ++++
 rtl/cv32e40x_obi_trans_responder.sv | 100 ++++++++++
 tb/tb_cv32e40x_obi_trans_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_obi_trans_responder_if.sv
// Transaction-side and OBI-side signal bundle for the MPU/PMA bus responder.
// The slave modport is the responder's view; master is the MPU-plus-bus view.
interface cv32e40x_obi_trans_responder_if;
   logic        trans_valid_i;
   logic        trans_ready_o;
   logic [31:0] trans_addr_i;
   logic        trans_we_i;
   logic [3:0]  trans_be_i;
   logic [31:0] trans_wdata_i;

   logic        obi_req_o;
   logic        obi_gnt_i;
   logic [31:0] obi_addr_o;
   logic        obi_we_o;
   logic [3:0]  obi_be_o;
   logic [31:0] obi_wdata_o;
   logic        obi_rvalid_i;
   logic [31:0] obi_rdata_i;
   logic        obi_err_i;

   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        resp_we_o;
   logic [2:0]  outstanding_o;
   logic        one_txn_pend_n_o;
   logic        busy_o;

   modport slave (
      input  trans_valid_i, trans_addr_i, trans_we_i, trans_be_i, trans_wdata_i,
      input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
      output trans_ready_o,
      output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
      output resp_valid_o, resp_rdata_o, resp_err_o, resp_we_o,
      output outstanding_o, one_txn_pend_n_o, busy_o
   );

   modport master (
      output trans_valid_i, trans_addr_i, trans_we_i, trans_be_i, trans_wdata_i,
      output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
      input  trans_ready_o,
      input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
      input  resp_valid_o, resp_rdata_o, resp_err_o, resp_we_o,
      input  outstanding_o, one_txn_pend_n_o, busy_o
   );
endinterface

// File: rtl/cv32e40x_obi_trans_responder.sv
// Holds one MPU transaction as a stable OBI address phase and returns in-order
// responses tagged with the access type recorded at grant.
module cv32e40x_obi_trans_responder #(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input logic                           clk,
   input logic                           rst_n,
   cv32e40x_obi_trans_responder_if.slave bus
);

   localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   typedef logic [PtrW-1:0] ptr_t;

   logic                       r_req;
   logic [31:0]                r_addr;
   logic                       r_we;
   logic [3:0]                 r_be;
   logic [31:0]                r_wdata;
   logic [2:0]                 r_cnt;
   logic [MAX_OUTSTANDING-1:0] r_fifo;
   ptr_t                       r_wptr;
   ptr_t                       r_rptr;

   logic       w_ready;
   logic       w_accept;
   logic       w_grant;
   logic       w_pop;
   logic       w_req_n;
   logic [2:0] w_cnt_n;

   function automatic ptr_t ptr_inc(ptr_t p);
      return (p == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // A response in the same cycle frees a slot, so a full responder can still accept.
   always_comb begin
      w_ready  = (!r_req || bus.obi_gnt_i) &&
                 ((int'(r_cnt) + int'(r_req) - int'(bus.obi_rvalid_i)) < int'(MAX_OUTSTANDING));
      w_accept = bus.trans_valid_i && w_ready;
      w_grant  = r_req && bus.obi_gnt_i;
      w_pop    = bus.obi_rvalid_i && (r_cnt != '0);
      w_req_n  = w_accept || (r_req && !bus.obi_gnt_i);
      w_cnt_n  = r_cnt + {2'b00, w_grant} - {2'b00, w_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_fifo  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         r_req <= w_req_n;
         r_cnt <= w_cnt_n;
         if (w_accept) begin
            r_addr  <= bus.trans_addr_i;
            r_we    <= bus.trans_we_i;
            r_be    <= bus.trans_be_i;
            r_wdata <= bus.trans_wdata_i;
         end
         // Push the type of the transaction leaving the request register, not the new one.
         if (w_grant) begin
            r_fifo[r_wptr] <= r_we;
            r_wptr         <= ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= ptr_inc(r_rptr);
         end
      end
   end

   assign bus.trans_ready_o    = w_ready;
   assign bus.obi_req_o        = r_req;
   assign bus.obi_addr_o       = r_addr;
   assign bus.obi_we_o         = r_we;
   assign bus.obi_be_o         = r_be;
   assign bus.obi_wdata_o      = r_wdata;
   assign bus.resp_valid_o     = w_pop;
   assign bus.resp_rdata_o     = w_pop ? bus.obi_rdata_i : '0;
   assign bus.resp_err_o       = w_pop && bus.obi_err_i;
   assign bus.resp_we_o        = w_pop && r_fifo[r_rptr];
   assign bus.outstanding_o    = r_cnt;
   assign bus.busy_o           = r_req || (r_cnt != '0);
   assign bus.one_txn_pend_n_o = (({1'b0, w_cnt_n} + {3'b000, w_req_n}) == 4'd1);

   a_no_spurious_rvalid : assert property (
      @(posedge clk) disable iff (!rst_n) bus.obi_rvalid_i |-> (r_cnt != '0))
      else $warning("spurious obi rvalid dropped");

   a_addr_phase_stable : assert property (
      @(posedge clk) disable iff (!rst_n)
      (r_req && !bus.obi_gnt_i) |=> (r_req && $stable({r_addr, r_we, r_be, r_wdata})))
      else $error("obi address phase changed before grant");

endmodule

// File: tb/tb_cv32e40x_obi_trans_responder.sv
// Bench for the OBI transaction responder: directed scenarios with literal
// expectations, then random traffic against a queue-based model.
module tb_cv32e40x_obi_trans_responder;

   localparam int unsigned MaxOut = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cv32e40x_obi_trans_responder_if bus ();

   cv32e40x_obi_trans_responder #(
      .MAX_OUTSTANDING(MaxOut)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Model: the held transaction plus a queue of access types awaiting response.
   bit          m_held;
   logic [31:0] m_addr;
   logic        m_we;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   bit          m_pend[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_ready();
      int in_flight;
      in_flight = m_pend.size() + int'(m_held) - int'(bus.obi_rvalid_i);
      return (!m_held || bus.obi_gnt_i) && (in_flight < int'(MaxOut));
   endfunction

   function automatic bit exp_resp_valid();
      return bus.obi_rvalid_i && (m_pend.size() > 0);
   endfunction

   function automatic bit exp_one_pending();
      int pend_n;
      bit held_n;
      pend_n = m_pend.size() + int'(m_held && bus.obi_gnt_i) - int'(exp_resp_valid());
      held_n = (bus.trans_valid_i && exp_ready()) || (m_held && !bus.obi_gnt_i);
      return (pend_n + int'(held_n)) == 1;
   endfunction

   task automatic model_reset();
      m_held  = 1'b0;
      m_addr  = '0;
      m_we    = 1'b0;
      m_be    = '0;
      m_wdata = '0;
      m_pend.delete();
   endtask

   task automatic drive(bit v, logic [31:0] a, bit we, bit g, bit rv, logic [31:0] rd, bit er);
      bus.trans_valid_i = v;
      bus.trans_addr_i  = a;
      bus.trans_we_i    = we;
      bus.trans_be_i    = 4'($urandom);
      bus.trans_wdata_i = $urandom;
      bus.obi_gnt_i     = g;
      bus.obi_rvalid_i  = rv;
      bus.obi_rdata_i   = rd;
      bus.obi_err_i     = er;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      bit          acc;
      bit          gr;
      bit          rv;
      logic [31:0] a;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wd;
      acc = bus.trans_valid_i && exp_ready();
      gr  = m_held && bus.obi_gnt_i;
      rv  = exp_resp_valid();
      a   = bus.trans_addr_i;
      we  = bus.trans_we_i;
      be  = bus.trans_be_i;
      wd  = bus.trans_wdata_i;
      @(posedge clk);
      if (rv) void'(m_pend.pop_front());
      if (gr) m_pend.push_back(m_we);
      if (acc) begin
         m_held  = 1'b1;
         m_addr  = a;
         m_we    = we;
         m_be    = be;
         m_wdata = wd;
      end else if (gr) begin
         m_held = 1'b0;
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         bit rv_exp;
         rv_exp = exp_resp_valid();
         chk("trans_ready", bus.trans_ready_o, exp_ready());
         chk("obi_req", bus.obi_req_o, m_held);
         chk("obi_addr", bus.obi_addr_o, m_addr);
         chk("obi_we", bus.obi_we_o, m_we);
         chk("obi_be", bus.obi_be_o, m_be);
         chk("obi_wdata", bus.obi_wdata_o, m_wdata);
         chk("resp_valid", bus.resp_valid_o, rv_exp);
         chk("resp_rdata", bus.resp_rdata_o, rv_exp ? bus.obi_rdata_i : 32'h0);
         chk("resp_err", bus.resp_err_o, rv_exp && bus.obi_err_i);
         chk("resp_we", bus.resp_we_o, rv_exp ? m_pend[0] : 1'b0);
         chk("outstanding", bus.outstanding_o, m_pend.size());
         chk("busy", bus.busy_o, m_held || (m_pend.size() > 0));
         chk("one_txn_pend_n", bus.one_txn_pend_n_o, exp_one_pending());
      end
   end

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_ready", bus.trans_ready_o, 1);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_one_pend", bus.one_txn_pend_n_o, 0);
      chk("rst_obi_req", bus.obi_req_o, 0);
      chk("rst_obi_addr", bus.obi_addr_o, 0);
      chk("rst_outstanding", bus.outstanding_o, 0);
      tick();

      // Single read, grant delayed 3 cycles
      drive(1, 32'h1000, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t1_ready", bus.trans_ready_o, 1);
      chk("t1_one_pend_accept", bus.one_txn_pend_n_o, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_req_held", bus.obi_req_o, 1);
         chk("t1_addr_held", bus.obi_addr_o, 32'h1000);
         tick();
      end
      drive(0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("t1_one_pend_grant", bus.one_txn_pend_n_o, 1);
      tick();
      drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
      @(negedge clk);
      chk("t1_cnt_after_gnt", bus.outstanding_o, 1);
      chk("t1_resp_valid", bus.resp_valid_o, 1);
      chk("t1_resp_we", bus.resp_we_o, 0);
      chk("t1_resp_rdata", bus.resp_rdata_o, 32'hDEAD_BEEF);
      chk("t1_one_pend_rvalid", bus.one_txn_pend_n_o, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t1_cnt_final", bus.outstanding_o, 0);
      chk("t1_busy_final", bus.busy_o, 0);
      tick();

      // Back-to-back write then read with grant held high, then full and rvalid cases
      drive(1, 32'h2000, 1, 1, 0, 0, 0);
      @(negedge clk);
      chk("t2_ready_a", bus.trans_ready_o, 1);
      tick();
      drive(1, 32'h2004, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("t2_ready_b", bus.trans_ready_o, 1);
      chk("t2_obi_we_a", bus.obi_we_o, 1);
      tick();
      drive(1, 32'h2008, 1, 1, 0, 0, 0);
      @(negedge clk);
      chk("t2_full_ready_c", bus.trans_ready_o, 0);
      chk("t2_cnt_one", bus.outstanding_o, 1);
      tick();
      @(negedge clk);
      chk("t2_full_ready_d", bus.trans_ready_o, 0);
      chk("t2_cnt_two", bus.outstanding_o, 2);
      chk("t2_req_clear", bus.obi_req_o, 0);
      tick();
      drive(1, 32'h2008, 1, 1, 1, 32'h11, 0);
      @(negedge clk);
      chk("t2_ready_rvalid", bus.trans_ready_o, 1);
      chk("t2_resp_we_first", bus.resp_we_o, 1);
      tick();
      drive(0, 0, 0, 1, 1, 32'h22, 0);
      @(negedge clk);
      chk("t2_resp_we_second", bus.resp_we_o, 0);
      chk("t2_full_rvalid_ready", bus.trans_ready_o, 1);
      chk("t2_addr_c", bus.obi_addr_o, 32'h2008);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t2_cnt_kept", bus.outstanding_o, 1);
      tick();
      drive(0, 0, 0, 0, 1, 32'h33, 1);
      @(negedge clk);
      chk("t2_err_resp", bus.resp_err_o, 1);
      chk("t2_err_we", bus.resp_we_o, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("t2_err_no_rvalid", bus.resp_err_o, 0);
      chk("t2_cnt_empty", bus.outstanding_o, 0);
      tick();

      // Reset with a held request and one outstanding
      drive(1, 32'h3000, 0, 0, 0, 0, 0);
      tick();
      drive(1, 32'h3004, 1, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t3_pre_req", bus.obi_req_o, 1);
      chk("t3_pre_cnt", bus.outstanding_o, 1);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t3_req_async_drop", bus.obi_req_o, 0);
      chk("t3_cnt_cleared", bus.outstanding_o, 0);
      #1 rst_n = 1'b1;
      drive(0, 0, 0, 0, 1, 32'h0BAD, 0);
      tick();
      @(negedge clk);
      chk("t3_spurious_resp", bus.resp_valid_o, 0);
      chk("t3_spurious_cnt", bus.outstanding_o, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t3_cnt_after", bus.outstanding_o, 0);
      tick();

      // Random traffic, checked every cycle against the model
      for (int i = 0; i < 3000; i++) begin
         bit v;
         bit g;
         bit rv;
         v  = ($urandom_range(0, 99) < 60);
         g  = ($urandom_range(0, 99) < 50);
         rv = (m_pend.size() > 0) && ($urandom_range(0, 99) < 45);
         drive(v, $urandom, 1'($urandom), g, rv, $urandom, 1'($urandom));
         tick();
      end

      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
